// File: rtl/hgcal_fc_manager_periodic_l1a_multi_if.sv
// Bus bundle for the multi-channel periodic L1A generator: programming and
// timing inputs toward the generator, fire and monitoring outputs back.
interface hgcal_fc_manager_periodic_l1a_multi_if #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PRESCALE_W = 20,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned SRC_W = $clog2(N_CH + 1);

  logic [N_CH-1:0]            enable;
  logic                       request_single;
  logic [11:0]                bx_single;
  logic [11:0]                bx_now;
  logic [N_CH*12-1:0]         bx_target;
  logic [N_CH*PRESCALE_W-1:0] prescale;
  logic                       clear_counters;
  logic                       fire;
  logic [SRC_W-1:0]           fire_src;
  logic [N_CH-1:0]            pending;
  logic                       veto_out;
  logic [CNT_W-1:0]           overrun_count;
  logic [CNT_W-1:0]           collision_count;

  modport master (
    output enable, request_single, bx_single, bx_now, bx_target, prescale, clear_counters,
    input  fire, fire_src, pending, veto_out, overrun_count, collision_count
  );

  modport slave (
    input  enable, request_single, bx_single, bx_now, bx_target, prescale, clear_counters,
    output fire, fire_src, pending, veto_out, overrun_count, collision_count
  );
endinterface

// File: rtl/hgcal_fc_manager_periodic_l1a_multi.sv
// Multi-channel periodic L1A generator: per-channel orbit prescalers arm requests that fire
// at a programmed BX, plus one software request, arbitrated to at most one L1A per BX.
module hgcal_fc_manager_periodic_l1a_multi #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PRESCALE_W = 20,
  parameter int unsigned CNT_W      = 16
) (
  input logic clk40,
  input logic reset,
  hgcal_fc_manager_periodic_l1a_multi_if.slave bus
);
  localparam int unsigned SRC_W      = $clog2(N_CH + 1);
  localparam logic [11:0] BxPerOrbit = 12'd3564;

  logic [N_CH-1:0][PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]                 pending_q, pending_d;
  logic                            single_pending_q, single_pending_d;
  logic [11:0]                     single_bx_q, single_bx_d;
  logic                            fire_q, fire_d;
  logic [SRC_W-1:0]                fire_src_q, fire_src_d;
  logic [CNT_W-1:0]                overrun_q, overrun_d;
  logic [CNT_W-1:0]                collision_q, collision_d;

  logic            bx_zero;
  logic [N_CH-1:0] arrival;
  logic [N_CH-1:0] ready_ch;
  logic            ready_single;
  logic [N_CH:0]   ready_all;
  logic            win_found;
  logic            any_overrun;
  logic            any_collision;

  assign bx_zero = (bus.bx_now == 12'd0);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [11:0]           tgt;
    logic [PRESCALE_W-1:0] ps;
    logic                  period_end;

    assign tgt        = bus.bx_target[12*g +: 12];
    assign ps         = bus.prescale[PRESCALE_W*g +: PRESCALE_W];
    assign period_end = (cnt_q[g] == ps);
    assign arrival[g] = bus.enable[g] && bx_zero && period_end;
    // Disabled channels are never ready, even if the pending flag is still set this cycle.
    assign ready_ch[g] = bus.enable[g] && pending_q[g] && (tgt < BxPerOrbit) &&
                         (bus.bx_now == tgt);

    always_comb begin
      cnt_d[g] = cnt_q[g];
      if (!bus.enable[g]) begin
        cnt_d[g] = '0;
      end else if (bx_zero) begin
        cnt_d[g] = period_end ? '0 : cnt_q[g] + 1'b1;
      end
    end
  end

  assign ready_single = single_pending_q && (single_bx_q < BxPerOrbit) &&
                        (bus.bx_now == single_bx_q);
  assign ready_all    = {ready_single, ready_ch};
  // More than one ready bit means at least one source lost arbitration.
  assign any_collision = |(ready_all & (ready_all - 1'b1));
  assign any_overrun   = (|(arrival & pending_q)) || (bus.request_single && single_pending_q);

  always_comb begin
    pending_d        = pending_q;
    single_pending_d = single_pending_q;
    single_bx_d      = single_bx_q;
    fire_d           = 1'b0;
    fire_src_d       = fire_src_q;
    win_found        = 1'b0;

    for (int ch = 0; ch < N_CH; ch++) begin
      if (ready_ch[ch] && !win_found) begin
        win_found     = 1'b1;
        fire_d        = 1'b1;
        fire_src_d    = SRC_W'(ch);
        pending_d[ch] = 1'b0;
      end
    end
    if (ready_single && !win_found) begin
      fire_d           = 1'b1;
      fire_src_d       = SRC_W'(N_CH);
      single_pending_d = 1'b0;
    end

    // New arrivals are applied after the winner clear so a fresh period is never lost.
    pending_d = (pending_d | arrival) & bus.enable;
    if (bus.request_single) begin
      single_pending_d = 1'b1;
      single_bx_d      = bus.bx_single;
    end
  end

  always_comb begin
    overrun_d   = overrun_q;
    collision_d = collision_q;
    if (bus.clear_counters) begin
      overrun_d   = '0;
      collision_d = '0;
    end else begin
      if (any_overrun && (overrun_q != '1)) begin
        overrun_d = overrun_q + 1'b1;
      end
      if (any_collision && (collision_q != '1)) begin
        collision_d = collision_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      cnt_q            <= '0;
      pending_q        <= '0;
      single_pending_q <= 1'b0;
      single_bx_q      <= '0;
      fire_q           <= 1'b0;
      fire_src_q       <= '0;
      overrun_q        <= '0;
      collision_q      <= '0;
    end else begin
      cnt_q            <= cnt_d;
      pending_q        <= pending_d;
      single_pending_q <= single_pending_d;
      single_bx_q      <= single_bx_d;
      fire_q           <= fire_d;
      fire_src_q       <= fire_src_d;
      overrun_q        <= overrun_d;
      collision_q      <= collision_d;
    end
  end

  assign bus.fire            = fire_q;
  assign bus.fire_src        = fire_src_q;
  assign bus.pending         = pending_q;
  assign bus.veto_out        = (|pending_q) || single_pending_q;
  assign bus.overrun_count   = overrun_q;
  assign bus.collision_count = collision_q;
endmodule

// File: tb/tb_hgcal_fc_manager_periodic_l1a_multi.sv
// Bench for the multi-channel periodic L1A generator: directed scenarios plus random traffic,
// all compared every cycle against an orbit-counting reference model.
module tb_hgcal_fc_manager_periodic_l1a_multi;
  localparam int unsigned NCh  = 4;
  localparam int unsigned PsW  = 20;
  localparam int unsigned CntW = 16;
  localparam int          CntMax = (1 << CntW) - 1;

  logic clk40 = 1'b0;
  logic reset = 1'b1;
  always #5 clk40 = ~clk40;

  hgcal_fc_manager_periodic_l1a_multi_if #(.N_CH(NCh), .PRESCALE_W(PsW), .CNT_W(CntW)) bus ();

  hgcal_fc_manager_periodic_l1a_multi #(.N_CH(NCh), .PRESCALE_W(PsW), .CNT_W(CntW)) dut (
    .clk40 (clk40),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state (m_*) is the expected post-edge view; n_* is the pending next state.
  int m_orb[NCh];  int n_orb[NCh];
  bit m_pend[NCh]; bit n_pend[NCh];
  bit m_sp, n_sp;
  int m_sbx, n_sbx;
  bit m_fire, n_fire;
  int m_src, n_src;
  int m_ovr, n_ovr;
  int m_col, n_col;
  bit cmp_en = 1'b0;

  int fires_by_src[NCh+1];
  int last_fire_bx;
  int src_log[$];
  logic [NCh-1:0] exp_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_next();
    int bx = int'(bus.bx_now);
    int nready = 0;
    int win = -1;
    bit ev = 1'b0;
    if (reset) begin
      for (int ch = 0; ch < NCh; ch++) begin
        n_orb[ch] = 0;
        n_pend[ch] = 1'b0;
      end
      n_sp = 0; n_sbx = 0; n_fire = 0; n_src = 0; n_ovr = 0; n_col = 0;
      return;
    end
    for (int ch = 0; ch < NCh; ch++) begin
      int tgt = int'(bus.bx_target[12*ch +: 12]);
      if (bus.enable[ch] && m_pend[ch] && tgt < 3564 && tgt == bx) begin
        nready++;
        if (win < 0) win = ch;
      end
    end
    if (m_sp && m_sbx < 3564 && m_sbx == bx) begin
      nready++;
      if (win < 0) win = NCh;
    end
    for (int ch = 0; ch < NCh; ch++) begin
      int ps = int'(bus.prescale[PsW*ch +: PsW]);
      n_pend[ch] = m_pend[ch] && (win != ch);
      n_orb[ch]  = m_orb[ch];
      if (!bus.enable[ch]) begin
        n_orb[ch]  = 0;
        n_pend[ch] = 1'b0;
      end else if (bx == 0) begin
        // The k-th orbit start since enable (k from 0) is an arrival when k mod (ps+1) == ps.
        if ((m_orb[ch] % (ps + 1)) == ps) begin
          if (m_pend[ch]) ev = 1'b1;
          n_pend[ch] = 1'b1;
        end
        n_orb[ch] = m_orb[ch] + 1;
      end
    end
    n_sp  = m_sp && (win != NCh);
    n_sbx = m_sbx;
    if (bus.request_single) begin
      if (m_sp) ev = 1'b1;
      n_sp  = 1'b1;
      n_sbx = int'(bus.bx_single);
    end
    n_fire = (nready > 0);
    n_src  = (win >= 0) ? win : m_src;
    if (bus.clear_counters) begin
      n_ovr = 0;
      n_col = 0;
    end else begin
      n_ovr = (ev && m_ovr < CntMax) ? m_ovr + 1 : m_ovr;
      n_col = (nready > 1 && m_col < CntMax) ? m_col + 1 : m_col;
    end
  endtask

  task automatic step();
    int bx_edge = int'(bus.bx_now);
    model_next();
    @(posedge clk40);
    m_orb = n_orb; m_pend = n_pend; m_sp = n_sp; m_sbx = n_sbx;
    m_fire = n_fire; m_src = n_src; m_ovr = n_ovr; m_col = n_col;
    @(negedge clk40);
    if (bus.fire === 1'b1) begin
      if (int'(bus.fire_src) <= NCh) fires_by_src[bus.fire_src]++;
      src_log.push_back(int'(bus.fire_src));
      last_fire_bx = bx_edge + 1;
    end
  endtask

  always @(negedge clk40) begin
    if (cmp_en) begin
      for (int i = 0; i < NCh; i++) exp_pend[i] = m_pend[i];
      chk("fire", bus.fire, m_fire);
      chk("fire_src", bus.fire_src, m_src);
      chk("pending", bus.pending, exp_pend);
      chk("veto_out", bus.veto_out, (|exp_pend) || m_sp);
      chk("overrun_count", bus.overrun_count, m_ovr);
      chk("collision_count", bus.collision_count, m_col);
    end
  end

  task automatic clr_stats();
    for (int i = 0; i <= NCh; i++) fires_by_src[i] = 0;
    last_fire_bx = -1;
    src_log.delete();
  endtask

  task automatic set_ch(input int ch, input int ps, input int tgt);
    bus.prescale[PsW*ch +: PsW] = PsW'(ps);
    bus.bx_target[12*ch +: 12]  = 12'(tgt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.request_single = 1'b0;
    bus.clear_counters = 1'b0;
    bus.bx_now = '0;
    step();
    step();
    reset = 1'b0;
    clr_stats();
  endtask

  task automatic run_orbits(input int n, input int len);
    for (int o = 0; o < n; o++) begin
      for (int b = 0; b < len; b++) begin
        bus.bx_now = 12'(b);
        step();
      end
    end
  endtask

  initial begin
    bus.enable = '0; bus.request_single = 1'b0; bus.bx_single = 12'd4000;
    bus.bx_now = '0; bus.bx_target = '0; bus.prescale = '0; bus.clear_counters = 1'b0;
    for (int ch = 0; ch < NCh; ch++) set_ch(ch, 0, 4000);
    do_reset();
    cmp_en = 1'b1;
    chk("reset_fire", bus.fire, 1'b0);
    chk("reset_src", bus.fire_src, 0);
    chk("reset_pending", bus.pending, 0);
    chk("reset_counters", {bus.overrun_count, bus.collision_count}, 0);

    // Every-orbit channel over full-length orbits.
    set_ch(0, 0, 100);
    bus.enable = 4'b0001;
    do_reset();
    run_orbits(2, 3564);
    chk("t1_fires", fires_by_src[0], 2);
    chk("t1_fire_bx", last_fire_bx, 101);

    // Prescale 2: one fire per three orbits.
    set_ch(0, 0, 4000);
    set_ch(1, 2, 50);
    bus.enable = 4'b0010;
    do_reset();
    run_orbits(6, 100);
    chk("t2_fires", fires_by_src[1], 2);
    chk("t2_overrun", bus.overrun_count, 0);

    // Same target on ch0 and ch2: ch2 starves.
    set_ch(1, 0, 4000);
    set_ch(0, 0, 200);
    set_ch(2, 0, 200);
    bus.enable = 4'b0101;
    do_reset();
    run_orbits(3, 300);
    chk("t3_ch0_fires", fires_by_src[0], 3);
    chk("t3_ch2_fires", fires_by_src[2], 0);
    chk("t3_collision", bus.collision_count, 3);
    chk("t3_overrun", bus.overrun_count, 2);

    // Single request colliding with ch3 at the same BX.
    set_ch(0, 0, 4000);
    set_ch(2, 0, 4000);
    set_ch(3, 1, 10);
    bus.bx_single = 12'd10;
    bus.enable = 4'b1000;
    do_reset();
    run_orbits(1, 100);
    for (int b = 0; b < 100; b++) begin
      bus.bx_now = 12'(b);
      bus.request_single = (b == 5);
      step();
    end
    bus.request_single = 1'b0;
    run_orbits(1, 100);
    chk("t4_nfires", src_log.size(), 2);
    if (src_log.size() == 2) begin
      chk("t4_first_src", src_log[0], 3);
      chk("t4_second_src", src_log[1], 4);
    end

    // Disable while pending, then reset mid-orbit.
    set_ch(3, 0, 4000);
    set_ch(1, 0, 150);
    bus.enable = 4'b0010;
    do_reset();
    for (int b = 0; b < 200; b++) begin
      bus.bx_now = 12'(b);
      if (b == 50) begin
        chk("t5_pend_before", bus.pending[1], 1'b1);
        bus.enable = 4'b0000;
      end
      step();
      if (b == 50) chk("t5_pend_after", bus.pending[1], 1'b0);
    end
    run_orbits(1, 200);
    chk("t5_fires", fires_by_src[1], 0);
    for (int ch = 0; ch < NCh; ch++) set_ch(ch, 0, 250);
    set_ch(2, 0, 20);
    bus.enable = 4'b1111;
    do_reset();
    for (int b = 0; b <= 100; b++) begin
      bus.bx_now = 12'(b);
      step();
    end
    chk("t5_veto_pre", bus.veto_out, 1'b1);
    chk("t5_src_pre", bus.fire_src, 2);
    reset = 1'b1;
    bus.bx_now = 12'd101;
    step();
    reset = 1'b0;
    chk("t5_rst_outputs", {bus.fire, bus.fire_src, bus.pending, bus.veto_out}, 0);
    chk("t5_rst_counters", {bus.overrun_count, bus.collision_count}, 0);

    // Overrun saturation via repeated single requests at an unreachable BX.
    bus.enable = '0;
    do_reset();
    bus.bx_now = 12'd5;
    bus.bx_single = 12'd4000;
    bus.request_single = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    chk("t6_sat", bus.overrun_count, 16'hFFFF);
    step();
    chk("t6_hold", bus.overrun_count, 16'hFFFF);
    bus.clear_counters = 1'b1;
    step();
    bus.clear_counters = 1'b0;
    bus.request_single = 1'b0;
    chk("t6_clear", bus.overrun_count, 0);

    // Random traffic on short orbits.
    for (int e = 0; e < 4; e++) begin
      for (int ch = 0; ch < NCh; ch++) set_ch(ch, $urandom_range(3), $urandom_range(70));
      bus.enable = 4'($urandom);
      do_reset();
      for (int o = 0; o < 4; o++) begin
        for (int b = 0; b < 64; b++) begin
          bus.bx_now = 12'(b);
          bus.request_single = ($urandom_range(15) == 0);
          bus.bx_single = ($urandom_range(7) == 0) ? 12'd3600 : 12'($urandom_range(70));
          bus.clear_counters = ($urandom_range(299) == 0);
          if ($urandom_range(199) == 0) bus.enable[$urandom_range(NCh-1)] ^= 1'b1;
          reset = ($urandom_range(999) == 0);
          step();
        end
      end
      reset = 1'b0;
      bus.request_single = 1'b0;
      bus.clear_counters = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hgcal_fc_manager_periodic_l1a_multi.md
# hgcal_fc_manager_periodic_l1a_multi

Multi-channel periodic L1A generator for the fast-control manager. Each of N_CH independent channels counts orbits, arms a request every prescale+1 orbits, and fires at its own programmed BX; a single software-triggered request shares the output. A fixed-priority arbiter emits at most one L1A per BX, with saturating overrun and collision counters for monitoring.

## Interface
- N_CH, 4, number of periodic channels (1..8)
- PRESCALE_W, 20, width of per-channel orbit prescale
- CNT_W, 16, width of monitoring counters
- SRC_W, derived as clog2(N_CH+1), width of fire_src (local, not overridable)

- clk40  in  1  40 MHz bunch clock
- reset  in  1  synchronous, active-high
- enable  in  N_CH  per-channel enable; low holds that channel in reset
- request_single  in  1  one-cycle pulse requesting one L1A
- bx_single  in  12  target BX for request_single
- bx_now  in  12  current BX, 0..3563, wraps to 0 at orbit start
- bx_target  in  N_CH*12  per-channel target BX, channel ch at [12*ch +: 12]
- prescale  in  N_CH*PRESCALE_W  per-channel prescale, channel ch at [PRESCALE_W*ch +: PRESCALE_W]
- clear_counters  in  1  synchronous clear of both monitoring counters
- fire  out  1  registered L1A pulse, one cycle
- fire_src  out  SRC_W  source of current fire: channel index, or N_CH for single
- pending  out  N_CH  per-channel armed flags (registers)
- veto_out  out  1  OR of pending and single-pending
- overrun_count  out  CNT_W  saturating count of period arrivals while already pending
- collision_count  out  CNT_W  saturating count of BX cycles where a ready source lost arbitration

## Operation
- Reset: all orbit counters, pending, single_pending, fire, fire_src, both counters = 0.
- Per channel ch (enable[ch]=1): on a cycle with bx_now==0, if cnt[ch]==prescale[ch] then cnt[ch]<=0 and arrival; else cnt[ch]<=cnt[ch]+1. prescale=0 arms every orbit; prescale=N arms every N+1 orbits.
- Arrival sets pending[ch]. If pending[ch] already 1: stays 1 (merged), overrun_count += 1.
- enable[ch]=0: cnt[ch]<=0, pending[ch]<=0 the next edge, including mid-pending; no fire from that channel.
- request_single sets single_pending regardless of enable; a second pulse while pending merges and counts as overrun. Simultaneous overruns from several sources in one cycle add 1 total.
- Ready source: pending (or single_pending) and bx_now equals its target. Arbitration: lowest channel index wins; single has lowest priority (index N_CH).
- Winner: pending cleared, fire<=1, fire_src<=index. Losers stay pending, fire at their target on a later orbit; collision_count += 1 per cycle with ≥1 loser.
- No ready source: fire<=0, fire_src holds previous value.
- Targets ≥3564 never match; such pending flags persist until disabled or reset.
- Counters saturate at all-ones; clear_counters wins over increment in the same cycle.

## Timing
- Arrival at edge where bx_now==0 sampled; pending visible next cycle.
- Fire: fire high in the cycle after the edge sampling bx_now==target with source pending; latency 1 clk.
- Arrival and target both at BX 0 in the same orbit: pending not yet set when compared, so fire occurs at BX 0 of the following orbit.
- request_single and bx_now==bx_single in the same cycle: fires on next match (next orbit).
- veto_out combinational from registers; drops the cycle fire rises.
- reset mid-pending: all flags cleared next edge, no fire issued.

## Test plan
- N_CH=4, ch0 prescale=0, target=100: fire at BX 101 every orbit, fire_src=0, pending high from BX 1 to BX 101.
- ch1 prescale=2, target=50: fire in every third orbit only; overrun_count stays 0.
- ch0 and ch2 both target=200, prescale=0: ch0 fires each orbit, ch2 never fires, collision_count increments once per orbit, overrun_count increments for ch2 each orbit after first.
- request_single with bx_single=10 while ch3 target=10 pending: ch3 fires (src=3), single fires next orbit (src=4).
- Drop enable[1] while pending[1]=1: pending clears next cycle, no fire; reset asserted mid-orbit clears all outputs to 0.
- Force 65535 overruns then one more: overrun_count holds 0xFFFF; clear_counters returns 0.
